// File: rtl/cve2_load_resp_align.sv
// cve2_load_resp_align: load-response stage between the data bus and the
// writeback passthrough. Latches per-load attributes at issue, collects one
// beat (aligned or in-word loads) or two beats (word-crossing loads), then
// aligns, merges and sign/zero-extends the data into an RF write.
//
// Optional feature: define CVE2_LSU_RESP_REG_EN to register the completion
// outputs (one extra cycle of response latency). Undefined, completion is
// combinational from data_rvalid_i.
module cve2_load_resp_align #(
    parameter bit MisalignedEn = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_offset_i,
    input  logic [1:0]  req_type_i,
    input  logic        req_sign_ext_i,
    input  logic        req_is_float_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    input  logic        data_err_i,
    output logic [31:0] rf_wdata_lsu_o,
    output logic        rf_we_lsu_o,
    output logic        lsu_resp_valid_o,
    output logic        lsu_resp_err_o,
    output logic        is_float_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ONLY,
        WAIT_FIRST,
        WAIT_SECOND
    } state_e;

    state_e      state_q;
    logic [1:0]  offset_q;
    logic [1:0]  type_q;
    logic        sign_ext_q;
    logic        is_float_q;
    logic [31:0] low_q;
    logic        err_q;
    logic        misalign_err_q;

    logic        req_word;
    logic        req_cross;
    logic        req_split;
    logic        req_misalign_err;

    logic [4:0]  shift_lo;
    logic [4:0]  shift_hi;
    logic [31:0] raw_data;
    logic [31:0] ext_data;

    logic        complete;
    logic        resp_err_c;
    logic        we_c;
    logic [31:0] wdata_c;
    logic        is_float_c;

    // Classify the incoming request: does it straddle a word boundary, and
    // is it split into two beats or rejected as a misaligned error.
    always_comb begin
        req_word         = (req_type_i == 2'b00) || (req_type_i == 2'b11);
        req_cross        = (req_word && (req_offset_i != 2'd0)) ||
                           ((req_type_i == 2'b01) && (req_offset_i == 2'd3));
        req_split        = MisalignedEn && req_cross;
        req_misalign_err = !MisalignedEn && req_cross;
    end

    // Load sequencing: latch attributes at issue, hold the low part and a
    // sticky error between the two beats of a split load.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            offset_q       <= 2'd0;
            type_q         <= 2'd0;
            sign_ext_q     <= 1'b0;
            is_float_q     <= 1'b0;
            low_q          <= 32'd0;
            err_q          <= 1'b0;
            misalign_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        offset_q       <= req_offset_i;
                        type_q         <= req_type_i;
                        sign_ext_q     <= req_sign_ext_i;
                        is_float_q     <= req_is_float_i;
                        err_q          <= 1'b0;
                        misalign_err_q <= req_misalign_err;
                        state_q        <= req_split ? WAIT_FIRST : WAIT_ONLY;
                    end
                end
                WAIT_FIRST: begin
                    if (data_rvalid_i) begin
                        low_q   <= data_rdata_i >> shift_lo;
                        err_q   <= data_err_i;
                        state_q <= WAIT_SECOND;
                    end
                end
                WAIT_ONLY, WAIT_SECOND: begin
                    if (data_rvalid_i) begin
                        low_q          <= 32'd0;
                        err_q          <= 1'b0;
                        misalign_err_q <= 1'b0;
                        state_q        <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Align the beat data: single beats shift down by the offset, second
    // beats supply the upper bytes above the stored low part.
    always_comb begin
        shift_lo = {offset_q, 3'b000};
        shift_hi = 5'(6'd32 - {1'b0, offset_q, 3'b000});
        if (state_q == WAIT_SECOND) begin
            raw_data = low_q | (data_rdata_i << shift_hi);
        end else begin
            raw_data = data_rdata_i >> shift_lo;
        end
    end

    // Sign or zero extension according to the latched access size.
    always_comb begin
        case (type_q)
            2'b01:   ext_data = {{16{sign_ext_q & raw_data[15]}}, raw_data[15:0]};
            2'b10:   ext_data = {{24{sign_ext_q & raw_data[7]}}, raw_data[7:0]};
            default: ext_data = raw_data;
        endcase
    end

    // Completion signalling; the write data is forced to zero without a
    // write so the writeback OR-mux never sees stray bits.
    always_comb begin
        complete   = data_rvalid_i && ((state_q == WAIT_ONLY) || (state_q == WAIT_SECOND));
        resp_err_c = complete && (data_err_i || err_q || misalign_err_q);
        we_c       = complete && !resp_err_c;
        wdata_c    = we_c ? ext_data : 32'd0;
        is_float_c = (state_q != IDLE) && is_float_q;
    end

`ifdef CVE2_LSU_RESP_REG_EN
    // Registered completion outputs, presented the cycle after the beat.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rf_wdata_lsu_o   <= 32'd0;
            rf_we_lsu_o      <= 1'b0;
            lsu_resp_valid_o <= 1'b0;
            lsu_resp_err_o   <= 1'b0;
            is_float_o       <= 1'b0;
        end else begin
            rf_wdata_lsu_o   <= wdata_c;
            rf_we_lsu_o      <= we_c;
            lsu_resp_valid_o <= complete;
            lsu_resp_err_o   <= resp_err_c;
            is_float_o       <= is_float_c;
        end
    end
`else
    // Combinational completion outputs, zero added latency.
    always_comb begin
        rf_wdata_lsu_o   = wdata_c;
        rf_we_lsu_o      = we_c;
        lsu_resp_valid_o = complete;
        lsu_resp_err_o   = resp_err_c;
        is_float_o       = is_float_c;
    end
`endif

    // Handshake status derived directly from the state.
    always_comb begin
        req_ready_o = (state_q == IDLE);
        busy_o      = (state_q != IDLE);
    end

`ifndef SYNTHESIS
    // New requests may only be issued while no load is outstanding.
    req_while_busy : assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q != IDLE) |-> !req_valid_i);

    // Bus beats must only arrive for an outstanding load.
    rvalid_while_idle : assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == IDLE) |-> !data_rvalid_i);
`endif

endmodule

// File: tb/tb_cve2_load_resp_align.sv
// tb_cve2_load_resp_align: directed-vector bench with a scoreboard. Each
// issued load pushes its hand-computed response; monitors pop and compare
// whenever a DUT presents lsu_resp_valid_o. A second instance built with
// MisalignedEn=0 covers the single-beat misaligned error path.
module tb_cve2_load_resp_align;

    typedef struct {
        logic [31:0] wdata;
        logic        we;
        logic        err;
        logic        isf;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_valid_nm;
    logic [1:0]  req_offset;
    logic [1:0]  req_type;
    logic        req_sign_ext;
    logic        req_is_float;
    logic        rvalid;
    logic        rvalid_nm;
    logic [31:0] rdata;
    logic        rerr;

    logic        ready, ready_nm;
    logic [31:0] wdata, wdata_nm;
    logic        we, we_nm;
    logic        valid, valid_nm;
    logic        err, err_nm;
    logic        isf, isf_nm;
    logic        busy, busy_nm;

    exp_t exp_q[$];
    exp_t exp_nm_q[$];
    int   total = 0;
    int   bad   = 0;

    cve2_load_resp_align #(.MisalignedEn(1'b1)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(ready),
        .req_offset_i(req_offset), .req_type_i(req_type),
        .req_sign_ext_i(req_sign_ext), .req_is_float_i(req_is_float),
        .data_rvalid_i(rvalid), .data_rdata_i(rdata), .data_err_i(rerr),
        .rf_wdata_lsu_o(wdata), .rf_we_lsu_o(we),
        .lsu_resp_valid_o(valid), .lsu_resp_err_o(err),
        .is_float_o(isf), .busy_o(busy)
    );

    cve2_load_resp_align #(.MisalignedEn(1'b0)) dut_nm (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid_nm), .req_ready_o(ready_nm),
        .req_offset_i(req_offset), .req_type_i(req_type),
        .req_sign_ext_i(req_sign_ext), .req_is_float_i(req_is_float),
        .data_rvalid_i(rvalid_nm), .data_rdata_i(rdata), .data_err_i(rerr),
        .rf_wdata_lsu_o(wdata_nm), .rf_we_lsu_o(we_nm),
        .lsu_resp_valid_o(valid_nm), .lsu_resp_err_o(err_nm),
        .is_float_o(isf_nm), .busy_o(busy_nm)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Scoreboard monitor for the MisalignedEn=1 instance.
    always @(negedge clk) begin
        if (!rst && valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_resp: got valid=1 wdata=0x%08h expected no response", wdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("wdata", wdata, e.wdata);
                checkOutput("we", 32'(we), 32'(e.we));
                checkOutput("err", 32'(err), 32'(e.err));
                checkOutput("is_float", 32'(isf), 32'(e.isf));
            end
        end
    end

    // Scoreboard monitor for the MisalignedEn=0 instance.
    always @(negedge clk) begin
        if (!rst && valid_nm) begin
            if (exp_nm_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_resp_nm: got valid=1 wdata=0x%08h expected no response", wdata_nm);
            end else begin
                exp_t e;
                e = exp_nm_q.pop_front();
                checkOutput("nm_wdata", wdata_nm, e.wdata);
                checkOutput("nm_we", 32'(we_nm), 32'(e.we));
                checkOutput("nm_err", 32'(err_nm), 32'(e.err));
                checkOutput("nm_is_float", 32'(isf_nm), 32'(e.isf));
            end
        end
    end

    // One complete load: issue, one wait cycle, then the beats back to back.
    task automatic applyStimulus(input bit nm, input logic [1:0] off, input logic [1:0] typ,
                                 input bit sext, input bit fl, input int beats,
                                 input logic [31:0] d0, input logic [31:0] d1,
                                 input bit e0, input bit e1,
                                 input logic [31:0] xw, input bit xwe, input bit xerr);
        exp_t e;
        bit   comb_mode;
`ifdef CVE2_LSU_RESP_REG_EN
        comb_mode = 1'b0;
`else
        comb_mode = 1'b1;
`endif
        e.wdata = xw;
        e.we    = xwe;
        e.err   = xerr;
        e.isf   = fl;
        @(posedge clk); #1;
        req_offset   = off;
        req_type     = typ;
        req_sign_ext = sext;
        req_is_float = fl;
        if (nm) begin
            req_valid_nm = 1'b1;
            exp_nm_q.push_back(e);
        end else begin
            req_valid = 1'b1;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        req_valid    = 1'b0;
        req_valid_nm = 1'b0;
        @(negedge clk);
        checkOutput("busy", 32'(nm ? busy_nm : busy), 32'd1);
        checkOutput("ready_busy", 32'(nm ? ready_nm : ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("is_float_busy", 32'(nm ? isf_nm : isf), 32'(fl));
        for (int i = 0; i < beats; i++) begin
            @(posedge clk); #1;
            rdata = (i == 0) ? d0 : d1;
            rerr  = (i == 0) ? e0 : e1;
            if (nm) rvalid_nm = 1'b1;
            else    rvalid    = 1'b1;
            @(negedge clk);
            checkOutput("beat_valid", 32'(nm ? valid_nm : valid),
                        32'((i == beats - 1) && comb_mode));
        end
        @(posedge clk); #1;
        rvalid    = 1'b0;
        rvalid_nm = 1'b0;
        rerr      = 1'b0;
        if (!comb_mode) begin
            @(negedge clk);
            checkOutput("reg_valid", 32'(nm ? valid_nm : valid), 32'd1);
            checkOutput("reg_ready", 32'(nm ? ready_nm : ready), 32'd1);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("idle_ready", 32'(nm ? ready_nm : ready), 32'd1);
        checkOutput("idle_is_float", 32'(nm ? isf_nm : isf), 32'd0);
    endtask

    // Directed test sequence.
    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_valid_nm = 1'b0;
        req_offset   = 2'd0;
        req_type     = 2'd0;
        req_sign_ext = 1'b0;
        req_is_float = 1'b0;
        rvalid       = 1'b0;
        rvalid_nm    = 1'b0;
        rdata        = 32'd0;
        rerr         = 1'b0;

        #2;
        checkOutput("rst_ready", 32'(ready), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_valid", 32'(valid), 32'd0);
        checkOutput("rst_we", 32'(we), 32'd0);
        checkOutput("rst_wdata", wdata, 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_is_float", 32'(isf), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        applyStimulus(0, 2'd0, 2'b00, 0, 0, 1, 32'hDEADBEEF, 32'h0, 0, 0, 32'hDEADBEEF, 1, 0);
        applyStimulus(0, 2'd2, 2'b10, 1, 0, 1, 32'h00800000, 32'h0, 0, 0, 32'hFFFFFF80, 1, 0);
        applyStimulus(0, 2'd2, 2'b10, 0, 0, 1, 32'h00800000, 32'h0, 0, 0, 32'h00000080, 1, 0);
        applyStimulus(0, 2'd1, 2'b00, 0, 0, 2, 32'h44332211, 32'h88776655, 0, 0, 32'h55443322, 1, 0);
        applyStimulus(0, 2'd3, 2'b01, 1, 0, 2, 32'hAA000000, 32'h000000FF, 0, 0, 32'hFFFFFFAA, 1, 0);
        applyStimulus(0, 2'd3, 2'b01, 1, 0, 2, 32'hAA000000, 32'h000000FF, 1, 0, 32'h00000000, 0, 1);
        applyStimulus(0, 2'd2, 2'b01, 1, 0, 1, 32'h80010000, 32'h0, 0, 0, 32'hFFFF8001, 1, 0);
        applyStimulus(0, 2'd0, 2'b11, 0, 1, 1, 32'hCAFEF00D, 32'h0, 0, 0, 32'hCAFEF00D, 1, 0);
        applyStimulus(0, 2'd0, 2'b00, 0, 0, 1, 32'h12345678, 32'h0, 1, 0, 32'h00000000, 0, 1);
        applyStimulus(0, 2'd3, 2'b10, 1, 0, 1, 32'h7F000000, 32'h0, 0, 0, 32'h0000007F, 1, 0);
        applyStimulus(0, 2'd3, 2'b00, 0, 0, 2, 32'h11223344, 32'h55667788, 0, 0, 32'h66778811, 1, 0);
        applyStimulus(1, 2'd2, 2'b00, 0, 0, 1, 32'h12345678, 32'h0, 0, 0, 32'h00000000, 0, 1);

        // Reset while waiting for the second beat of a split load.
        @(posedge clk); #1;
        req_offset   = 2'd1;
        req_type     = 2'b00;
        req_sign_ext = 1'b0;
        req_is_float = 1'b0;
        req_valid    = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rdata     = 32'h44332211;
        rvalid    = 1'b1;
        @(posedge clk); #1;
        rvalid = 1'b0;
        @(negedge clk);
        checkOutput("mid_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid_rst_ready", 32'(ready), 32'd1);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_valid", 32'(valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        applyStimulus(0, 2'd0, 2'b00, 0, 0, 1, 32'hA5A55A5A, 32'h0, 0, 0, 32'hA5A55A5A, 1, 0);

        repeat (3) @(posedge clk);
        checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
        checkOutput("queue_nm_empty", 32'(exp_nm_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cve2_load_resp_align.md
Name: cve2_load_resp_align

Overview:
- Load-response stage between the data bus and the writeback passthrough.
- Captures per-load attributes at issue and collects one or two bus response beats; two beats are needed for misaligned accesses.
- Aligns, merges and sign/zero-extends the load data.
- Produces the LSU-side register-file write (data, write-enable), the response valid/error pair and the float-destination flag consumed by writeback.

Parameters:
- MisalignedEn, 1, 1: split misaligned loads into two beats. 0: a misaligned request completes on its single beat with lsu_resp_err_o=1 and no RF write.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous active-high reset
- req_valid_i  input  1  load issued to the bus this cycle
- req_ready_o  output  1  block can accept a new load
- req_offset_i  input  2  byte address offset (addr[1:0])
- req_type_i  input  2  00 word, 01 half, 10 byte, 11 reserved (treated as word)
- req_sign_ext_i  input  1  sign-extend half/byte
- req_is_float_i  input  1  destination is the FP register file
- data_rvalid_i  input  1  bus response beat valid
- data_rdata_i  input  32  bus response data
- data_err_i  input  1  bus response error
- rf_wdata_lsu_o  output  32  aligned and extended load data
- rf_we_lsu_o  output  1  RF write request from the load
- lsu_resp_valid_o  output  1  load completed this cycle
- lsu_resp_err_o  output  1  completed load had an error
- is_float_o  output  1  float flag of the load in flight
- busy_o  output  1  load outstanding

Behaviour:
- Reset: state IDLE; all attribute and data registers cleared; every output 0 except req_ready_o=1.
- States:
  - IDLE: no load outstanding.
  - WAIT_ONLY: single-beat load, waiting for its only beat.
  - WAIT_FIRST: split load, waiting for beat 1.
  - WAIT_SECOND: split load, waiting for beat 2.
- IDLE:
  - req_ready_o=1.
  - req_valid_i latches offset, type, sign_ext and is_float.
  - Split condition: (word & offset!=0) | (half & offset==3), with MisalignedEn=1.
  - Go to WAIT_FIRST if split, otherwise WAIT_ONLY.
- In every state other than IDLE: req_ready_o=0, busy_o=1; req_valid_i is ignored (protocol violation, asserted).
- WAIT_FIRST, on rvalid:
  - Store rdata as the low part: rdata >> (8*offset).
  - Store err in a sticky error flag.
  - Go to WAIT_SECOND.
  - No outputs asserted.
- WAIT_ONLY or WAIT_SECOND, on rvalid (completion cycle, combinational from rvalid, zero added latency):
  - lsu_resp_valid_o=1.
  - lsu_resp_err_o = data_err_i | sticky error.
  - rf_we_lsu_o = ~lsu_resp_err_o.
  - Next state IDLE; the sticky error clears.
- Merge for split loads: raw = stored_low | (rdata << (8*(4-offset))), truncated to 32 bits.
- Single-beat loads: raw = rdata >> (8*offset).
- Extension:
  - word: raw.
  - half: raw[15:0] extended using bit 15 when sign_ext, else zero-extended.
  - byte: raw[7:0] extended the same way using bit 7.
- rf_wdata_lsu_o is 0 whenever rf_we_lsu_o=0, so the writeback OR-mux stays clean.
- is_float_o: the latched flag while busy, 0 in IDLE.
- Back-to-back loads: a new request is accepted only in IDLE, so the earliest next issue is the cycle after completion.
- MisalignedEn=0 with a misaligned request: goes to WAIT_ONLY; on its beat, lsu_resp_err_o=1 and rf_we_lsu_o=0.
- rvalid while IDLE: ignored, no outputs asserted (asserted as an error).
- Reset asserted mid-load: asynchronously back to IDLE; any pending beat is dropped.

Optional Feature:
- Macro: CVE2_LSU_RESP_REG_EN.
- Defined:
  - Completion outputs (rf_wdata_lsu_o, rf_we_lsu_o, lsu_resp_valid_o, lsu_resp_err_o, is_float_o) are registered, adding 1 cycle of latency.
  - The state returns to IDLE one cycle later, so req_ready_o rises in the cycle the registered response is presented.
  - The output registers reset to 0.
- Undefined: combinational completion as described in Behaviour.

Test Plan:
- Aligned word, offset 0, rdata=0xDEADBEEF, no err -> same cycle: valid=1, we=1, wdata=0xDEADBEEF, err=0.
- Signed byte, offset 2, rdata=0x00800000 -> wdata=0xFFFFFF80. Same load with sign_ext=0 -> wdata=0x00000080.
- Misaligned word, offset 1, beats 0x44332211 then 0x88776655 -> no output on beat 1; on beat 2 wdata=0x55443322, we=1.
- Misaligned half, offset 3, signed, beats 0xAA000000 then 0x000000FF -> wdata=0xFFFFFFAA. Same load with err on beat 1 -> err=1, we=0, wdata=0.
- MisalignedEn=0, word, offset 2 -> single beat: valid=1, err=1, we=0. Reset asserted in WAIT_SECOND -> IDLE, req_ready_o=1, no response.
- CVE2_LSU_RESP_REG_EN defined, aligned word -> valid/we/wdata appear 1 cycle after rvalid. req_is_float_i=1 -> is_float_o=1 while busy.
